cmd_responder: RTL and testbench

Card-side end of the SD CMD line: the counterpart to the host CMD driver. It deserialises 48-bit host commands, checks the frame and CRC7, and presents the command index and argument to card logic. It then serialises the response that card logic supplies (R1-style, R2 or R3) after the Ncr gap. It is used as the card emulator in system benches and in loopback tests of the host SD core.

---
 rtl/cmd_responder_if.sv | 37 +++
 rtl/cmd_responder.sv | 189 ++++++++++++++++++
 tb/tb_cmd_responder.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_responder_if.sv
// Card-side SD CMD line bundle.
//   slave  : the responder (samples the host line, answers with responses)
//   master : host line driver + card logic (offers commands and responses)
// Signals:
//   icmd_sd                 host CMD line as seen by the card (idle high)
//   ocmd_sd / ocmd_oe       responder-driven CMD line and its output enable
//   ocmd_valid/index/arg    decoded good command
//   ocrc_err / oframe_err   receive error pulses
//   oresp_ready/iresp_*     response handshake and payload
//   oresp_timeout           no response offered in time
interface cmd_responder_if;
  logic         icmd_sd;
  logic         ocmd_sd;
  logic         ocmd_oe;
  logic         ocmd_valid;
  logic [5:0]   ocmd_index;
  logic [31:0]  ocmd_arg;
  logic         ocrc_err;
  logic         oframe_err;
  logic         oresp_ready;
  logic         iresp_valid;
  logic [1:0]   iresp_type;
  logic [119:0] iresp_data;
  logic         oresp_timeout;

  modport slave (
    input  icmd_sd, iresp_valid, iresp_type, iresp_data,
    output ocmd_sd, ocmd_oe, ocmd_valid, ocmd_index, ocmd_arg,
           ocrc_err, oframe_err, oresp_ready, oresp_timeout
  );

  modport master (
    output icmd_sd, iresp_valid, iresp_type, iresp_data,
    input  ocmd_sd, ocmd_oe, ocmd_valid, ocmd_index, ocmd_arg,
           ocrc_err, oframe_err, oresp_ready, oresp_timeout
  );
endinterface

// File: rtl/cmd_responder.sv
// SD card-side CMD responder: deserialises 48-bit host commands, checks the
// frame and CRC7, reports index/argument, then serialises the response
// (short with CRC, R2 or R3) supplied by card logic after the Ncr gap.
// Ports:
//   iclk  SD clock, rising edge
//   irst  synchronous active-high reset
//   bus   cmd_responder_if.slave (CMD line, decoded command, response handshake)
module cmd_responder #(
  parameter int NCR     = 2,
  parameter int NCR_MAX = 64
) (
  input  logic            iclk,
  input  logic            irst,
  cmd_responder_if.slave  bus
);
  typedef enum logic [2:0] {
    IDLE, RCV_CMD, RCV_CRC, RCV_END, WAIT_RESP, SEND_RESP, SEND_CRC, SEND_END
  } state_t;

  localparam int         TW      = $clog2(NCR_MAX + 1);
  localparam logic [1:0] T_NONE  = 2'b00;
  localparam logic [1:0] T_R2    = 2'b10;
  localparam logic [1:0] T_R3    = 2'b11;

  // x^7 + x^3 + 1, serial MSB-first form
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  endfunction

  state_t         state;
  logic [38:0]    rx_sr;
  logic [6:0]     rx_crc;
  logic [6:0]     crc;
  logic [5:0]     rcnt;
  logic [126:0]   tx_sr;
  logic [6:0]     bcnt;     // payload bits still to drive after the start bit
  logic [2:0]     ccnt;
  logic [1:0]     tx_type;
  logic [6:0]     wcnt;
  logic [TW-1:0]  tcnt;

  logic           cmd_sd, cmd_oe, cmd_valid, crc_err, frame_err;
  logic           resp_ready, resp_timeout;
  logic [5:0]     cmd_index;
  logic [31:0]    cmd_arg;

  // R2 CRC covers only the 120 data bits: skip transmission bit + 6'b111111
  logic tx_crc_en;
  assign tx_crc_en = (tx_type != T_R2) || (bcnt <= 7'd120);

  always_ff @(posedge iclk) begin
    if (irst) begin
      state        <= IDLE;
      rx_sr        <= '0;
      rx_crc       <= '0;
      crc          <= '0;
      rcnt         <= '0;
      tx_sr        <= '0;
      bcnt         <= '0;
      ccnt         <= '0;
      tx_type      <= T_NONE;
      wcnt         <= '0;
      tcnt         <= '0;
      cmd_sd       <= 1'b1;
      cmd_oe       <= 1'b0;
      cmd_valid    <= 1'b0;
      crc_err      <= 1'b0;
      frame_err    <= 1'b0;
      resp_ready   <= 1'b0;
      resp_timeout <= 1'b0;
      cmd_index    <= '0;
      cmd_arg      <= '0;
    end else begin
      cmd_valid    <= 1'b0;
      crc_err      <= 1'b0;
      frame_err    <= 1'b0;
      resp_timeout <= 1'b0;
      case (state)
        IDLE: if (!bus.icmd_sd) begin
          // start bit is 0, so a zero-initialised CRC is unchanged by it
          state <= RCV_CMD;
          rcnt  <= 6'd38;
          crc   <= '0;
        end
        RCV_CMD: begin
          rx_sr <= {rx_sr[37:0], bus.icmd_sd};
          crc   <= crc7_step(crc, bus.icmd_sd);
          if (rcnt == 6'd0) begin
            state <= RCV_CRC;
            rcnt  <= 6'd6;
          end else rcnt <= rcnt - 6'd1;
        end
        RCV_CRC: begin
          rx_crc <= {rx_crc[5:0], bus.icmd_sd};
          if (rcnt == 6'd0) state <= RCV_END;
          else              rcnt  <= rcnt - 6'd1;
        end
        RCV_END: begin
          if (!rx_sr[38] || !bus.icmd_sd) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else if (rx_crc != crc) begin
            crc_err <= 1'b1;
            state   <= IDLE;
          end else begin
            cmd_valid <= 1'b1;
            cmd_index <= rx_sr[37:32];
            cmd_arg   <= rx_sr[31:0];
            wcnt      <= '0;
            tcnt      <= '0;
            state     <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (!resp_ready) begin
            if (wcnt == 7'(NCR - 2)) resp_ready <= 1'b1;
            else                     wcnt       <= wcnt + 7'd1;
          end else if (bus.iresp_valid) begin
            resp_ready <= 1'b0;
            tx_type    <= bus.iresp_type;
            crc        <= '0;
            if (bus.iresp_type == T_NONE) begin
              state <= IDLE;
            end else begin
              // start bit goes out now; tx_sr holds the rest left-aligned
              cmd_sd <= 1'b0;
              cmd_oe <= 1'b1;
              state  <= SEND_RESP;
              if (bus.iresp_type == T_R2) begin
                tx_sr <= {1'b0, 6'h3F, bus.iresp_data};
                bcnt  <= 7'd127;
              end else begin
                tx_sr <= {1'b0, (bus.iresp_type == T_R3) ? 6'h3F : cmd_index,
                          bus.iresp_data[31:0], 88'd0};
                bcnt  <= 7'd39;
              end
            end
          end else if (tcnt == TW'(NCR_MAX - 1)) begin
            resp_ready   <= 1'b0;
            resp_timeout <= 1'b1;
            state        <= IDLE;
          end else tcnt <= tcnt + 1'b1;
        end
        SEND_RESP: begin
          if (bcnt != 7'd0) begin
            cmd_sd <= tx_sr[126];
            tx_sr  <= {tx_sr[125:0], 1'b0};
            if (tx_crc_en) crc <= crc7_step(crc, tx_sr[126]);
            bcnt   <= bcnt - 7'd1;
          end else begin
            // payload done: first CRC bit (all ones for R3)
            cmd_sd <= (tx_type == T_R3) | crc[6];
            crc    <= {crc[5:0], 1'b0};
            ccnt   <= 3'd6;
            state  <= SEND_CRC;
          end
        end
        SEND_CRC: begin
          if (ccnt != 3'd0) begin
            cmd_sd <= (tx_type == T_R3) | crc[6];
            crc    <= {crc[5:0], 1'b0};
            ccnt   <= ccnt - 3'd1;
          end else begin
            cmd_sd <= 1'b1;  // end bit
            state  <= SEND_END;
          end
        end
        SEND_END: begin
          cmd_sd <= 1'b1;
          cmd_oe <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ocmd_sd       = cmd_sd;
  assign bus.ocmd_oe       = cmd_oe;
  assign bus.ocmd_valid    = cmd_valid;
  assign bus.ocmd_index    = cmd_index;
  assign bus.ocmd_arg      = cmd_arg;
  assign bus.ocrc_err      = crc_err;
  assign bus.oframe_err    = frame_err;
  assign bus.oresp_ready   = resp_ready;
  assign bus.oresp_timeout = resp_timeout;
endmodule

// File: tb/tb_cmd_responder.sv
module tb_cmd_responder;
  localparam int NCR     = 3;
  localparam int NCR_MAX = 24;

  logic iclk, irst;
  cmd_responder_if bus();

  cmd_responder #(.NCR(NCR), .NCR_MAX(NCR_MAX)) dut (
    .iclk(iclk), .irst(irst), .bus(bus)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  int n_cmp = 0;
  int n_err = 0;
  int oe_cnt = 0;
  always @(posedge iclk) if (bus.ocmd_oe === 1'b1) oe_cnt <= oe_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got hang required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge iclk);
    #1;
  endtask

  // Remainder of M(x)*x^7 divided by x^7+x^3+1 (long division)
  function automatic logic [6:0] crc7_div(input logic [135:0] msg, input int nbits);
    logic [7:0] r;
    logic b;
    r = '0;
    for (int i = nbits - 1; i >= -7; i--) begin
      b = (i >= 0) ? msg[i] : 1'b0;
      r = {r[6:0], b};
      if (r[7]) r = r ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic logic [47:0] mk_cmd(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] h;
    h = {2'b01, idx, arg};
    return {h, crc7_div({96'd0, h}, 40), 1'b1};
  endfunction

  task automatic send_frame(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      bus.icmd_sd = f[i];
      step();
    end
    bus.icmd_sd = 1'b1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (bus.oresp_ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic wait_oe(output int n);
    n = 0;
    while (bus.ocmd_oe !== 1'b1 && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic capture(output logic [135:0] bits, output int n);
    bits = '0;
    n = 0;
    while (bus.ocmd_oe === 1'b1 && n < 200) begin
      bits = {bits[134:0], bus.ocmd_sd};
      n++;
      step();
    end
  endtask

  task automatic resp_none();
    bus.iresp_type  = 2'b00;
    bus.iresp_valid = 1'b1;
    step();
    bus.iresp_valid = 1'b0;
  endtask

  typedef struct {
    logic [47:0] frame;
    logic        valid;
    logic        cerr;
    logic        ferr;
    logic [5:0]  idx;
    logic [31:0] arg;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int n, base;
    logic [135:0] bits;
    logic [119:0] d2;

    tbl[0] = '{48'h48_000001AA_87, 1'b1, 1'b0, 1'b0, 6'd8,  32'h000001AA};
    tbl[1] = '{48'h40_00000000_97, 1'b0, 1'b1, 1'b0, 6'd8,  32'h000001AA};
    tbl[2] = '{48'h77_00000000_65, 1'b1, 1'b0, 1'b0, 6'd55, 32'h00000000};
    tbl[3] = '{48'h40_00000000_94, 1'b0, 1'b0, 1'b1, 6'd55, 32'h00000000};
    tbl[4] = '{48'h00_00000000_95, 1'b0, 1'b0, 1'b1, 6'd55, 32'h00000000};
    tbl[5] = '{48'h40_00000000_95, 1'b1, 1'b0, 1'b0, 6'd0,  32'h00000000};
    tbl[6] = '{48'h40_00000000_96, 1'b0, 1'b0, 1'b1, 6'd0,  32'h00000000};

    irst = 1'b1;
    bus.icmd_sd     = 1'b1;
    bus.iresp_valid = 1'b0;
    bus.iresp_type  = 2'b00;
    bus.iresp_data  = '0;
    repeat (3) step();
    chk("rst_sd",    136'(bus.ocmd_sd), 136'(1));
    chk("rst_oe",    136'(bus.ocmd_oe), 136'(0));
    chk("rst_ready", 136'(bus.oresp_ready), 136'(0));
    chk("rst_pulses", 136'({bus.ocmd_valid, bus.ocrc_err, bus.oframe_err, bus.oresp_timeout}), 136'(0));
    chk("rst_index", 136'(bus.ocmd_index), 136'(0));
    chk("rst_arg",   136'(bus.ocmd_arg), 136'(0));
    irst = 1'b0;
    repeat (2) step();

    // Table: receive checks; good commands answered with type 00
    for (int i = 0; i < 7; i++) begin
      base = oe_cnt;
      send_frame(tbl[i].frame);
      chk($sformatf("t%0d_valid", i), 136'(bus.ocmd_valid), 136'(tbl[i].valid));
      chk($sformatf("t%0d_crcerr", i), 136'(bus.ocrc_err), 136'(tbl[i].cerr));
      chk($sformatf("t%0d_frmerr", i), 136'(bus.oframe_err), 136'(tbl[i].ferr));
      chk($sformatf("t%0d_index", i), 136'(bus.ocmd_index), 136'(tbl[i].idx));
      chk($sformatf("t%0d_arg", i), 136'(bus.ocmd_arg), 136'(tbl[i].arg));
      if (tbl[i].valid) begin
        wait_ready(n);
        chk($sformatf("t%0d_ready_lat", i), 136'(n), 136'(NCR - 1));
        resp_none();
        repeat (3) step();
        chk($sformatf("t%0d_no_oe", i), 136'(oe_cnt - base), 136'(0));
      end else begin
        step();
        chk($sformatf("t%0d_pulse_clr", i), 136'({bus.ocrc_err, bus.oframe_err}), 136'(0));
        repeat (NCR + 3) step();
        chk($sformatf("t%0d_no_ready", i), 136'(bus.oresp_ready), 136'(0));
        chk($sformatf("t%0d_no_oe", i), 136'(oe_cnt - base), 136'(0));
      end
    end

    // CMD8 with short response held valid before ready
    bus.iresp_type  = 2'b01;
    bus.iresp_data  = 120'h1AA;
    bus.iresp_valid = 1'b1;
    send_frame(48'h48_000001AA_87);
    chk("r1_valid", 136'(bus.ocmd_valid), 136'(1));
    wait_oe(n);
    chk("r1_start_lat", 136'(n), 136'(NCR));
    bus.iresp_valid = 1'b0;
    bus.iresp_data  = '1;
    bus.iresp_type  = 2'b10;
    capture(bits, n);
    chk("r1_len", 136'(n), 136'(48));
    chk("r1_bits", 136'(bits[47:0]), 136'(48'h08_000001AA_13));
    chk("r1_idle_sd", 136'(bus.ocmd_sd), 136'(1));

    // R2, offered 10 cycles late; host line wiggles during the wait
    d2 = 120'h0123456789_ABCDEF0123_456789ABEF;
    send_frame(mk_cmd(6'd2, 32'h0));
    wait_ready(n);
    chk("r2_ready_lat", 136'(n), 136'(NCR - 1));
    for (int i = 0; i < 10; i++) begin
      bus.icmd_sd = i[0];
      step();
    end
    bus.icmd_sd = 1'b1;
    chk("r2_ready_held", 136'(bus.oresp_ready), 136'(1));
    bus.iresp_type  = 2'b10;
    bus.iresp_data  = d2;
    bus.iresp_valid = 1'b1;
    step();
    bus.iresp_valid = 1'b0;
    bus.iresp_data  = '0;
    capture(bits, n);
    chk("r2_len", 136'(n), 136'(136));
    chk("r2_bits", bits, {2'b00, 6'h3F, d2, crc7_div({16'd0, d2}, 120), 1'b1});
    chk("r2_idle_sd", 136'(bus.ocmd_sd), 136'(1));

    // R3
    send_frame(mk_cmd(6'd41, 32'h40FF8000));
    chk("r3_index", 136'(bus.ocmd_index), 136'(41));
    wait_ready(n);
    bus.iresp_type  = 2'b11;
    bus.iresp_data  = 120'h80FF8000;
    bus.iresp_valid = 1'b1;
    step();
    bus.iresp_valid = 1'b0;
    capture(bits, n);
    chk("r3_len", 136'(n), 136'(48));
    chk("r3_bits", 136'(bits[47:0]), 136'({2'b00, 6'h3F, 32'h80FF8000, 7'h7F, 1'b1}));

    // Timeout
    send_frame(mk_cmd(6'd0, 32'h0));
    wait_ready(n);
    n = 0;
    while (bus.oresp_timeout !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("to_lat", 136'(n), 136'(NCR_MAX));
    chk("to_ready_drop", 136'(bus.oresp_ready), 136'(0));
    step();
    chk("to_pulse_clr", 136'(bus.oresp_timeout), 136'(0));

    // Reset in mid-response, then a normal command
    bus.iresp_type  = 2'b01;
    bus.iresp_data  = 120'hDEADBEEF;
    bus.iresp_valid = 1'b1;
    send_frame(mk_cmd(6'd8, 32'h1AA));
    wait_oe(n);
    bus.iresp_valid = 1'b0;
    chk("rm_started", 136'(bus.ocmd_oe), 136'(1));
    repeat (10) step();
    irst = 1'b1;
    step();
    chk("rm_sd", 136'(bus.ocmd_sd), 136'(1));
    chk("rm_oe", 136'(bus.ocmd_oe), 136'(0));
    chk("rm_index", 136'(bus.ocmd_index), 136'(0));
    irst = 1'b0;
    step();
    base = oe_cnt;
    repeat (5) step();
    chk("rm_aborted", 136'(oe_cnt - base), 136'(0));
    send_frame(48'h77_00000000_65);
    chk("rm_next_valid", 136'(bus.ocmd_valid), 136'(1));
    chk("rm_next_index", 136'(bus.ocmd_index), 136'(55));
    wait_ready(n);
    resp_none();
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
